// File: rtl/octa_pkg.sv
// Shared Octa16 core types: register-file geometry, write-back request and write source.
package octa_pkg;

  localparam int DATA_W   = 8;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_LDQ,
    SRC_LDIN
  } wb_src_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    reg_onehot = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_ctrl_if.sv
// Write-back controller bus: issue, ALU and load result inputs, register-file write port, scoreboard.
interface wb_ctrl_if
  import octa_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
);

  logic             issue_vld;
  logic [AW-1:0]    issue_rd;
  logic             alu_vld;
  logic [AW-1:0]    alu_rd;
  logic [DW-1:0]    alu_data;
  logic             ld_vld;
  logic [AW-1:0]    ld_rd;
  logic [DW-1:0]    ld_data;
  logic             ld_rdy;
  logic             wrEn;
  logic [AW-1:0]    rd;
  logic [DW-1:0]    dIn;
  logic [2**AW-1:0] busy_vec;
  logic             err;

  modport slave (
    input  issue_vld, issue_rd, alu_vld, alu_rd, alu_data, ld_vld, ld_rd, ld_data,
    output ld_rdy, wrEn, rd, dIn, busy_vec, err
  );

  modport master (
    output issue_vld, issue_rd, alu_vld, alu_rd, alu_data, ld_vld, ld_rd, ld_data,
    input  ld_rdy, wrEn, rd, dIn, busy_vec, err
  );

endinterface

// File: rtl/wb_ldq.sv
// Load queue for the write-back controller: synchronous FIFO of wb_req_t, DEPTH a power of two.
module wb_ldq
  import octa_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;

  // Storage is not reset; count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_ctrl.sv
// Octa16 write-back controller: arbitrates ALU and load results onto the register-file port
// and tracks pending writes. Define WB_LDQ_EN to buffer colliding loads in a queue.
module wb_ctrl
  import octa_pkg::*;
#(
  parameter int DW       = DATA_W,
  parameter int AW       = REG_AW,
  parameter int LQ_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  wb_ctrl_if.slave   bus
);

  localparam int NR = 2**AW;

  wb_src_t       src;
  logic          sel_vld;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic          ld_acc;

  logic          wr_en_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] din_q;
  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_nxt;
  logic          err_q;

`ifdef WB_LDQ_EN
  logic    q_push;
  logic    q_pop;
  logic    q_full;
  logic    q_empty;
  wb_req_t q_din;
  wb_req_t q_dout;

  assign bus.ld_rdy = ~q_full;
  assign ld_acc     = bus.ld_vld & ~q_full;
  assign q_din      = wb_req_t'{rd: bus.ld_rd, data: bus.ld_data};
  assign q_push     = ld_acc & (src != SRC_LDIN);
  assign q_pop      = (src == SRC_LDQ);

  wb_ldq #(.DEPTH(LQ_DEPTH)) u_ldq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .din   (q_din),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );
`else
  assign bus.ld_rdy = ~bus.alu_vld;
  assign ld_acc     = bus.ld_vld & ~bus.alu_vld;
`endif

  // ALU first, then the oldest queued load, then a fresh load only when nothing is waiting.
  always_comb begin
    src      = SRC_NONE;
    sel_rd   = bus.alu_rd;
    sel_data = bus.alu_data;
    if (bus.alu_vld) begin
      src = SRC_ALU;
`ifdef WB_LDQ_EN
    end else if (!q_empty) begin
      src      = SRC_LDQ;
      sel_rd   = q_dout.rd;
      sel_data = q_dout.data;
`endif
    end else if (ld_acc) begin
      src      = SRC_LDIN;
      sel_rd   = bus.ld_rd;
      sel_data = bus.ld_data;
    end
  end

  assign sel_vld = (src != SRC_NONE);

  // A capture clears the bit shown on the port; a same-edge issue re-sets it.
  always_comb begin
    busy_nxt = busy_q;
    if (wr_en_q)       busy_nxt = busy_nxt & ~reg_onehot(rd_q);
    if (bus.issue_vld) busy_nxt = busy_nxt | reg_onehot(bus.issue_rd);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      din_q   <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      wr_en_q <= sel_vld;
      if (sel_vld) begin
        rd_q  <= sel_rd;
        din_q <= sel_data;
      end
      busy_q <= busy_nxt;
      if ((bus.issue_vld && busy_q[bus.issue_rd]) || (sel_vld && !busy_q[sel_rd]))
        err_q <= 1'b1;
    end
  end

  assign bus.wrEn     = wr_en_q;
  assign bus.rd       = rd_q;
  assign bus.dIn      = din_q;
  assign bus.busy_vec = busy_q;
  assign bus.err      = err_q;

endmodule
